conv_tuser_gen: RTL and testbench
=================================

Name: conv_tuser_gen

Overview:
- Sits on the AXI-Stream path feeding the conv engine, upstream of pad_filter, and is the transmitter side of the conv-in TUSER protocol that pad_filter decodes.
- Receives a config header beat, then the image beats in cin-innermost, column, then row-block order.
- Tags every outgoing beat with TUSER flags: IS_CONFIG, IS_CIN_LAST, IS_COLS_1_K2 and the KW2 field.
- Asserts TLAST on the final image beat.

Parameters:
- WORD_WIDTH, 64, width of s_data/m_data.
- BITS_COLS, 10, column counter width.
- BITS_CIN, 10, input-channel counter width.
- BITS_BLOCKS, 10, row-block counter width.
- TUSER_WIDTH, `TUSER_WIDTH_CONV_IN, m_user width.
- BITS_KW2, `BITS_KW2, kw/2 field width.

Ports:
- aclk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- aclken  in  1  global clock enable; when low, all state holds.
- s_valid  in  1  upstream beat valid.
- s_ready  out  1  upstream ready.
- s_data  in  WORD_WIDTH  upstream beat; the header beat carries config fields.
- m_valid  out  1  downstream valid.
- m_ready  in  1  downstream ready.
- m_data  out  WORD_WIDTH  registered copy of s_data.
- m_user  out  TUSER_WIDTH  flags at `I_IS_CONFIG, `I_IS_CIN_LAST, `I_IS_COLS_1_K2, and KW2 at `I_KW2; all other bits 0.
- m_last  out  1  final image beat.
- cfg_err  out  1  sticky error: the current config has cols_1 < kw2.

Behaviour:
- Reset (async, aresetn=0):
  - state=S_CFG; all counters 0.
  - m_valid=0, m_last=0, m_user=0, m_data=0, cfg_err=0.
- Output stage: one register stage.
  - s_ready = aclken & (!m_valid | m_ready).
  - A transfer occurs on s_valid & s_ready.
  - m_* load on a transfer.
  - m_valid clears when m_ready is high and no transfer occurs.
  - Latency is 1 cycle.
  - Backpressure holds m_* stable while m_valid & !m_ready.
- Header field layout, low bits first: kw2 [BITS_KW2], cols_1 [BITS_COLS], cin_1 [BITS_CIN], blocks_1 [BITS_BLOCKS]. The "_1" fields hold count-1.
- S_CFG, on transfer:
  - Latch the fields and emit the beat with IS_CONFIG=1, KW2=kw2, IS_CIN_LAST=0, IS_COLS_1_K2=0.
  - cfg_err <= (cols_1 < kw2).
  - Go to S_RUN with cin=col=blk=0.
- S_RUN, on each transfer, the emitted beat carries:
  - IS_CONFIG=0 and KW2=latched kw2.
  - IS_CIN_LAST = (cin==cin_1).
  - IS_COLS_1_K2 = (col == cols_1-kw2) & !cfg_err. This comparison is done at BITS_COLS+1 width with no wrap.
  - m_last = (cin==cin_1) & (col==cols_1) & (blk==blocks_1).
- Counter advance in S_RUN:
  - cin increments and wraps at cin_1.
  - On a cin wrap, col increments and wraps at cols_1.
  - On a col wrap, blk increments.
  - When all three wrap together (m_last beat): state goes to S_CFG and counters clear.
- Degenerate sizes:
  - cin_1=0: every beat is IS_CIN_LAST.
  - cols_1=0 and kw2=0: IS_COLS_1_K2 is set on every cin-last column, i.e. every beat with col=0.
  - All fields 0: a single image beat carrying IS_CIN_LAST and m_last.
- kw2=0 (kw=1): IS_COLS_1_K2 asserts at col==cols_1, and the consumer ignores it.
- cfg_err clears only on the next header or on reset. The image stream still passes through when it is set.
- aclken=0:
  - s_ready=0 and all registers hold.
  - m_valid is unchanged.
- A reset mid-frame returns to S_CFG, and the next beat is treated as a header.

Decomposition:
- Shared package conv_stream_pkg:
  - state enum {S_CFG, S_RUN};
  - a packed struct cfg_t {blocks_1, cin_1, cols_1, kw2} with its field widths;
  - TUSER index constants mirrored from params.v.
- One natural sub-module, axis_pipe_reg: a 1-stage valid/ready register for data+user+last.
- The counter nest stays inline.

Test Plan:
1. Header kw2=1, cols_1=3, cin_1=1, blocks_1=0, then 8 beats, m_ready=1 → expected beats:
   - beat 0 has IS_CONFIG=1, KW2=1;
   - IS_CIN_LAST on image beats 2,4,6,8;
   - IS_COLS_1_K2 on beats 5,6 (col=2);
   - m_last on beat 8;
   - then back in S_CFG.
2. Same config with m_ready toggling 1-0-0-1 → no beat lost or duplicated, m_data/m_user stable while stalled, and s_ready low while m_valid & !m_ready.
3. Header kw2=2, cols_1=1 → cfg_err=1 and IS_COLS_1_K2 never set. Next header kw2=0, cols_1=1 → cfg_err=0 and IS_COLS_1_K2 at col=1.
4. All fields 0 → header plus one image beat carrying IS_CIN_LAST=1, IS_COLS_1_K2=1, m_last=1.
5. aresetn pulsed low asynchronously at image beat 3 of test 1 → m_valid=0 immediately, and the next input beat is decoded as a header.
6. aclken held low for 5 cycles mid-frame with s_valid=1 → no transfers and counters frozen; the sequence resumes identically once aclken returns high.

Source files
------------

// File: rtl/conv_stream_pkg.sv
// Shared types and TUSER bit positions for the conv-in AXI-Stream path.
// Field widths here define the config header layout decoded by conv_tuser_gen.
package conv_stream_pkg;

  localparam int unsigned DATA_W   = 64;
  localparam int unsigned KW2_W    = 3;
  localparam int unsigned COLS_W   = 10;
  localparam int unsigned CIN_W    = 10;
  localparam int unsigned BLOCKS_W = 10;

  // TUSER layout of the conv-in stream, mirrored from params.v
  localparam int unsigned I_IS_CONFIG         = 0;
  localparam int unsigned I_IS_CIN_LAST       = 1;
  localparam int unsigned I_IS_COLS_1_K2      = 2;
  localparam int unsigned I_KW2               = 3;
  localparam int unsigned TUSER_WIDTH_CONV_IN = I_KW2 + KW2_W;

  typedef enum logic {
    S_CFG,
    S_RUN
  } state_t;

  // Header word layout, low bits first: kw2, cols_1, cin_1, blocks_1
  typedef struct packed {
    logic [BLOCKS_W-1:0] blocks_1;
    logic [CIN_W-1:0]    cin_1;
    logic [COLS_W-1:0]   cols_1;
    logic [KW2_W-1:0]    kw2;
  } cfg_t;

endpackage

// File: rtl/axis_pipe_reg.sv
// One-stage valid/ready register slice with a global clock enable.
// Ready is combinational so a full slice can accept a beat in the same cycle it drains.
module axis_pipe_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             in_valid,
  output logic             in_ready_c,
  input  logic [WIDTH-1:0] in_payload,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_payload
);

  assign in_ready_c = en & (~out_valid | out_ready);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid   <= 1'b0;
      out_payload <= '0;
    end else if (in_valid & in_ready_c) begin
      out_valid   <= 1'b1;
      out_payload <= in_payload;
    end else if (en & out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/conv_tuser_gen.sv
// Tags the conv-in stream with TUSER flags: a config header beat followed by
// image beats in cin-innermost, column, row-block order; TLAST on the final beat.
module conv_tuser_gen
  import conv_stream_pkg::*;
#(
  parameter int unsigned WORD_WIDTH  = DATA_W,
  parameter int unsigned BITS_COLS   = COLS_W,
  parameter int unsigned BITS_CIN    = CIN_W,
  parameter int unsigned BITS_BLOCKS = BLOCKS_W,
  parameter int unsigned TUSER_WIDTH = TUSER_WIDTH_CONV_IN,
  parameter int unsigned BITS_KW2    = KW2_W
) (
  input  logic                   aclk,
  input  logic                   aresetn,
  input  logic                   aclken,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [WORD_WIDTH-1:0]  s_data,
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic [WORD_WIDTH-1:0]  m_data,
  output logic [TUSER_WIDTH-1:0] m_user,
  output logic                   m_last,
  output logic                   cfg_err
);

  localparam int unsigned CMP_W = BITS_COLS + 1;
  localparam int unsigned PAY_W = 1 + TUSER_WIDTH + WORD_WIDTH;

  state_t                 state, state_n;
  cfg_t                   cfg_q, cfg_n, hdr;
  logic [BITS_CIN-1:0]    cin, cin_n;
  logic [BITS_COLS-1:0]   col, col_n;
  logic [BITS_BLOCKS-1:0] blk, blk_n;
  logic                   err_q, err_n;
  logic                   xfer;
  logic                   cin_last, col_last, blk_last;
  logic [CMP_W-1:0]       k2_col;
  logic [TUSER_WIDTH-1:0] user_c;
  logic                   last_c;

  assign xfer = s_valid & s_ready;

  always_comb begin
    hdr          = '0;
    hdr.kw2      = KW2_W'(s_data[0 +: BITS_KW2]);
    hdr.cols_1   = COLS_W'(s_data[BITS_KW2 +: BITS_COLS]);
    hdr.cin_1    = CIN_W'(s_data[BITS_KW2 + BITS_COLS +: BITS_CIN]);
    hdr.blocks_1 = BLOCKS_W'(s_data[BITS_KW2 + BITS_COLS + BITS_CIN +: BITS_BLOCKS]);
  end

  assign cin_last = (cin == BITS_CIN'(cfg_q.cin_1));
  assign col_last = (col == BITS_COLS'(cfg_q.cols_1));
  assign blk_last = (blk == BITS_BLOCKS'(cfg_q.blocks_1));
  // Widened so kw2 > cols_1 yields an unreachable column instead of wrapping
  assign k2_col   = CMP_W'(cfg_q.cols_1) - CMP_W'(cfg_q.kw2);

  always_comb begin
    state_n = state;
    cfg_n   = cfg_q;
    err_n   = err_q;
    cin_n   = cin;
    col_n   = col;
    blk_n   = blk;
    user_c  = '0;
    last_c  = 1'b0;
    case (state)
      S_CFG: begin
        user_c[I_IS_CONFIG]        = 1'b1;
        user_c[I_KW2 +: BITS_KW2]  = BITS_KW2'(hdr.kw2);
        if (xfer) begin
          cfg_n   = hdr;
          err_n   = (hdr.cols_1 < COLS_W'(hdr.kw2));
          state_n = S_RUN;
          cin_n   = '0;
          col_n   = '0;
          blk_n   = '0;
        end
      end
      S_RUN: begin
        user_c[I_KW2 +: BITS_KW2]  = BITS_KW2'(cfg_q.kw2);
        user_c[I_IS_CIN_LAST]      = cin_last;
        user_c[I_IS_COLS_1_K2]     = (CMP_W'(col) == k2_col) & ~err_q;
        last_c                     = cin_last & col_last & blk_last;
        if (xfer) begin
          if (!cin_last) begin
            cin_n = cin + BITS_CIN'(1);
          end else begin
            cin_n = '0;
            if (!col_last) begin
              col_n = col + BITS_COLS'(1);
            end else begin
              col_n = '0;
              if (!blk_last) begin
                blk_n = blk + BITS_BLOCKS'(1);
              end else begin
                blk_n   = '0;
                state_n = S_CFG;
              end
            end
          end
        end
      end
      default: state_n = S_CFG;
    endcase
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state <= S_CFG;
      cfg_q <= '0;
      err_q <= 1'b0;
      cin   <= '0;
      col   <= '0;
      blk   <= '0;
    end else if (aclken) begin
      state <= state_n;
      cfg_q <= cfg_n;
      err_q <= err_n;
      cin   <= cin_n;
      col   <= col_n;
      blk   <= blk_n;
    end
  end

  assign cfg_err = err_q;

  axis_pipe_reg #(
    .WIDTH(PAY_W)
  ) u_pipe (
    .clk        (aclk),
    .rst_n      (aresetn),
    .en         (aclken),
    .in_valid   (s_valid),
    .in_ready_c (s_ready),
    .in_payload ({last_c, user_c, s_data}),
    .out_valid  (m_valid),
    .out_ready  (m_ready),
    .out_payload({m_last, m_user, m_data})
  );

endmodule

// File: tb/tb_conv_tuser_gen.sv
// Bench for conv_tuser_gen: frames are expanded by a nested-loop reference model
// and compared beat by beat against what the DUT hands downstream.
module tb_conv_tuser_gen;
  import conv_stream_pkg::*;

  localparam int unsigned W      = DATA_W;
  localparam int unsigned UW     = TUSER_WIDTH_CONV_IN;
  localparam int unsigned HDR_W  = KW2_W + COLS_W + CIN_W + BLOCKS_W;
  localparam int          BUDGET = 3000;

  logic          aclk    = 1'b0;
  logic          aresetn = 1'b0;
  logic          aclken  = 1'b1;
  logic          s_valid = 1'b0;
  logic          s_ready;
  logic [W-1:0]  s_data  = '0;
  logic          m_valid;
  logic          m_ready = 1'b0;
  logic [W-1:0]  m_data;
  logic [UW-1:0] m_user;
  logic          m_last;
  logic          cfg_err;

  int tests = 0;
  int fails = 0;

  logic [W-1:0]  in_q[$];
  logic [W-1:0]  exp_d[$];
  logic [UW-1:0] exp_u[$];
  logic          exp_l[$];
  logic [W-1:0]  obs_d[$];
  logic [UW-1:0] obs_u[$];
  logic          obs_l[$];
  bit            exp_err;
  int            stall_errs, sready_errs, en_xfers;
  bit            timed_out;

  conv_tuser_gen dut (
    .aclk   (aclk),
    .aresetn(aresetn),
    .aclken (aclken),
    .s_valid(s_valid),
    .s_ready(s_ready),
    .s_data (s_data),
    .m_valid(m_valid),
    .m_ready(m_ready),
    .m_data (m_data),
    .m_user (m_user),
    .m_last (m_last),
    .cfg_err(cfg_err)
  );

  always #5 aclk = ~aclk;

  function automatic logic [UW-1:0] mk_user(bit is_cfg, bit cin_l, bit k2, int kw2);
    logic [UW-1:0] u;
    u                   = '0;
    u[I_IS_CONFIG]      = is_cfg;
    u[I_IS_CIN_LAST]    = cin_l;
    u[I_IS_COLS_1_K2]   = k2;
    u[I_KW2 +: KW2_W]   = KW2_W'(kw2);
    return u;
  endfunction

  // Reference frame: header beat, then blocks x cols x cin beats (cin innermost)
  task automatic build_frame(input int kw2, input int cols_1, input int cin_1, input int blocks_1);
    logic [W-1:0] hdr, d;
    in_q.delete(); exp_d.delete(); exp_u.delete(); exp_l.delete();
    exp_err = (cols_1 < kw2);
    hdr = {$urandom, $urandom};
    hdr[HDR_W-1:0] = {BLOCKS_W'(blocks_1), CIN_W'(cin_1), COLS_W'(cols_1), KW2_W'(kw2)};
    in_q.push_back(hdr);
    exp_d.push_back(hdr); exp_u.push_back(mk_user(1'b1, 1'b0, 1'b0, kw2)); exp_l.push_back(1'b0);
    for (int b = 0; b <= blocks_1; b++)
      for (int c = 0; c <= cols_1; c++)
        for (int i = 0; i <= cin_1; i++) begin
          d = {$urandom, $urandom};
          in_q.push_back(d);
          exp_d.push_back(d);
          exp_u.push_back(mk_user(1'b0, i == cin_1, (c == cols_1 - kw2) && !exp_err, kw2));
          exp_l.push_back(b == blocks_1 && c == cols_1 && i == cin_1);
        end
  endtask

  // mode 0: m_ready high, 1: 1-0-0-1 pattern, 2: random. en_start>=0 drops aclken for 5 cycles.
  task automatic run_stream(input int mode, input bit rand_valid, input int en_start);
    int in_idx = 0;
    int cyc = 0;
    bit prev_hold = 1'b0;
    bit en, mr;
    logic [W-1:0] pd;
    logic [UW-1:0] pu;
    logic pl, pv;
    obs_d.delete(); obs_u.delete(); obs_l.delete();
    stall_errs = 0; sready_errs = 0; en_xfers = 0; timed_out = 1'b0;
    pd = '0; pu = '0; pl = 1'b0; pv = 1'b0;
    while (obs_d.size() < exp_d.size() || in_idx < in_q.size()) begin
      if (cyc >= BUDGET) begin
        timed_out = 1'b1;
        break;
      end
      @(negedge aclk);
      en = !(en_start >= 0 && cyc >= en_start && cyc < en_start + 5);
      case (mode)
        0:       mr = 1'b1;
        1:       mr = (cyc % 4 == 0) || (cyc % 4 == 3);
        default: mr = ($urandom_range(0, 2) != 0);
      endcase
      if (!en) mr = 1'b0;
      aclken  = en;
      m_ready = mr;
      if (in_idx < in_q.size() && (!rand_valid || !en || $urandom_range(0, 3) != 0)) begin
        s_valid = 1'b1;
        s_data  = in_q[in_idx];
      end else begin
        s_valid = 1'b0;
        s_data  = {$urandom, $urandom};
      end
      #1;
      if (prev_hold && {m_valid, m_data, m_user, m_last} !== {pv, pd, pu, pl}) stall_errs++;
      if (s_ready !== (aclken && (!m_valid || m_ready))) sready_errs++;
      if (!aclken && s_valid && s_ready) en_xfers++;
      if (m_valid && m_ready && aclken) begin
        obs_d.push_back(m_data); obs_u.push_back(m_user); obs_l.push_back(m_last);
      end
      if (s_valid && s_ready) in_idx++;
      prev_hold = m_valid && (!m_ready || !aclken);
      pv = m_valid; pd = m_data; pu = m_user; pl = m_last;
      cyc++;
    end
    @(negedge aclk);
    s_valid = 1'b0;
    m_ready = 1'b0;
    aclken  = 1'b1;
  endtask

  task automatic test_reset;
    repeat (3) @(negedge aclk);
    #1;
    tests++;
    if ({m_valid, m_last, m_user, m_data, cfg_err} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got valid=%b last=%b user=%b data=%h err=%b, expected all zero",
               m_valid, m_last, m_user, m_data, cfg_err);
    end
    tests++;
    if (s_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_s_ready: got %b, expected 1", s_ready);
    end
    aresetn = 1'b1;
    @(negedge aclk);
  endtask

  task automatic test_basic;
    build_frame(1, 3, 1, 0);
    run_stream(0, 1'b0, -1);
    tests++;
    if (timed_out || obs_d.size() != exp_d.size()) begin
      fails++;
      $display("FAIL basic_count: got %0d beats (timeout=%0b), expected %0d", obs_d.size(), timed_out, exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      tests++;
      if ({obs_d[i], obs_u[i], obs_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL basic_beat%0d: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                 i, obs_d[i], obs_u[i], obs_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    tests++;
    if (stall_errs + sready_errs + en_xfers != 0) begin
      fails++;
      $display("FAIL basic_handshake: got stall=%0d sready=%0d en_xfer=%0d, expected 0", stall_errs, sready_errs, en_xfers);
    end
  endtask

  task automatic test_back_to_back;
    build_frame(1, 3, 1, 0);
    run_stream(1, 1'b0, -1);
    tests++;
    if (timed_out || obs_d.size() != exp_d.size()) begin
      fails++;
      $display("FAIL bp_count: got %0d beats (timeout=%0b), expected %0d", obs_d.size(), timed_out, exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      tests++;
      if ({obs_d[i], obs_u[i], obs_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL bp_beat%0d: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                 i, obs_d[i], obs_u[i], obs_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
    tests++;
    if (stall_errs + sready_errs != 0) begin
      fails++;
      $display("FAIL bp_stability: got stall=%0d sready=%0d, expected 0", stall_errs, sready_errs);
    end
  endtask

  task automatic test_cfg_err;
    int k2_seen;
    for (int pass = 0; pass < 2; pass++) begin
      if (pass == 0) build_frame(2, 1, 1, 1);
      else           build_frame(0, 1, 1, 1);
      run_stream(2, 1'b1, -1);
      tests++;
      if (cfg_err !== exp_err) begin
        fails++;
        $display("FAIL cfg_err_flag%0d: got %b, expected %b", pass, cfg_err, exp_err);
      end
      k2_seen = 0;
      for (int i = 0; i < obs_u.size(); i++) k2_seen += int'(obs_u[i][I_IS_COLS_1_K2]);
      tests++;
      if (timed_out || k2_seen != (pass == 0 ? 0 : 4)) begin
        fails++;
        $display("FAIL cfg_err_k2count%0d: got %0d (timeout=%0b), expected %0d", pass, k2_seen, timed_out, pass == 0 ? 0 : 4);
      end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
        tests++;
        if ({obs_d[i], obs_u[i], obs_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
          fails++;
          $display("FAIL cfg_err_beat%0d_%0d: got user=%b last=%b, expected user=%b last=%b",
                   pass, i, obs_u[i], obs_l[i], exp_u[i], exp_l[i]);
        end
      end
    end
  endtask

  task automatic test_all_zero;
    build_frame(0, 0, 0, 0);
    run_stream(0, 1'b0, -1);
    tests++;
    if (timed_out || obs_d.size() != 2) begin
      fails++;
      $display("FAIL zero_count: got %0d beats (timeout=%0b), expected 2", obs_d.size(), timed_out);
    end else begin
      tests++;
      if ({obs_u[1][I_IS_CONFIG], obs_u[1][I_IS_CIN_LAST], obs_u[1][I_IS_COLS_1_K2], obs_l[1]} !== 4'b0111) begin
        fails++;
        $display("FAIL zero_flags: got user=%b last=%b, expected cin_last=1 k2=1 last=1", obs_u[1], obs_l[1]);
      end
      tests++;
      if ({obs_d[0], obs_u[0], obs_l[0]} !== {exp_d[0], exp_u[0], exp_l[0]}) begin
        fails++;
        $display("FAIL zero_header: got data=%h user=%b, expected data=%h user=%b", obs_d[0], obs_u[0], exp_d[0], exp_u[0]);
      end
    end
  endtask

  task automatic test_reset_mid_frame;
    build_frame(1, 3, 1, 0);
    aclken  = 1'b1;
    m_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge aclk);
      s_valid = 1'b1;
      s_data  = in_q[i];
    end
    @(negedge aclk);
    s_valid = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b1 || m_data !== in_q[3]) begin
      fails++;
      $display("FAIL rst_mid_pre: got valid=%b data=%h, expected valid=1 data=%h", m_valid, m_data, in_q[3]);
    end
    m_ready = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    tests++;
    if (m_valid !== 1'b0 || m_last !== 1'b0 || m_user !== '0) begin
      fails++;
      $display("FAIL rst_mid_async: got valid=%b last=%b user=%b, expected 0", m_valid, m_last, m_user);
    end
    #1 aresetn = 1'b1;
    build_frame(3, 4, 0, 1);
    run_stream(2, 1'b1, -1);
    tests++;
    if (timed_out || obs_d.size() != exp_d.size()) begin
      fails++;
      $display("FAIL rst_mid_count: got %0d beats (timeout=%0b), expected %0d", obs_d.size(), timed_out, exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      tests++;
      if ({obs_d[i], obs_u[i], obs_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL rst_mid_beat%0d: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                 i, obs_d[i], obs_u[i], obs_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_clock_enable;
    build_frame(1, 3, 1, 0);
    run_stream(0, 1'b0, 4);
    tests++;
    if (stall_errs + sready_errs + en_xfers != 0) begin
      fails++;
      $display("FAIL clken_hold: got stall=%0d sready=%0d en_xfer=%0d, expected 0", stall_errs, sready_errs, en_xfers);
    end
    tests++;
    if (timed_out || obs_d.size() != exp_d.size()) begin
      fails++;
      $display("FAIL clken_count: got %0d beats (timeout=%0b), expected %0d", obs_d.size(), timed_out, exp_d.size());
    end
    for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
      tests++;
      if ({obs_d[i], obs_u[i], obs_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
        fails++;
        $display("FAIL clken_beat%0d: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                 i, obs_d[i], obs_u[i], obs_l[i], exp_d[i], exp_u[i], exp_l[i]);
      end
    end
  endtask

  task automatic test_random;
    int kw2, cols_1, cin_1, blocks_1;
    for (int f = 0; f < 8; f++) begin
      kw2      = $urandom_range(0, 3);
      cols_1   = $urandom_range(0, 4);
      cin_1    = $urandom_range(0, 3);
      blocks_1 = $urandom_range(0, 2);
      build_frame(kw2, cols_1, cin_1, blocks_1);
      run_stream(2, 1'b1, (f == 5) ? 7 : -1);
      tests++;
      if (timed_out || obs_d.size() != exp_d.size() || cfg_err !== exp_err) begin
        fails++;
        $display("FAIL rand%0d_frame: got %0d beats err=%b (timeout=%0b), expected %0d beats err=%b",
                 f, obs_d.size(), cfg_err, timed_out, exp_d.size(), exp_err);
      end
      for (int i = 0; i < exp_d.size() && i < obs_d.size(); i++) begin
        tests++;
        if ({obs_d[i], obs_u[i], obs_l[i]} !== {exp_d[i], exp_u[i], exp_l[i]}) begin
          fails++;
          $display("FAIL rand%0d_beat%0d: got data=%h user=%b last=%b, expected data=%h user=%b last=%b",
                   f, i, obs_d[i], obs_u[i], obs_l[i], exp_d[i], exp_u[i], exp_l[i]);
        end
      end
      tests++;
      if (stall_errs + sready_errs + en_xfers != 0) begin
        fails++;
        $display("FAIL rand%0d_handshake: got stall=%0d sready=%0d en_xfer=%0d, expected 0",
                 f, stall_errs, sready_errs, en_xfers);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_cfg_err();
    test_all_zero();
    test_reset_mid_frame();
    test_clock_enable();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
